logic_reduce_unit: RTL and testbench

Parametrised successor to the single-bit gate and XOR modules. Accepts a stream of WIDTH-bit words in frames and folds them bitwise with a selected operation (AND/OR/XOR/XNOR). It returns one result word per frame, with a beat count and a parity bit. Valid/ready handshakes on input and output let it sit between a switch/stimulus source and an LED/display sink on the lab board.

---
 rtl/lru_pkg.sv | 17 +
 rtl/lru_bitop.sv | 24 ++
 rtl/logic_reduce_unit.sv | 136 +++++++++++++
 tb/tb_logic_reduce_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared types for logic_reduce_unit: fold operation codes and FSM states.
package lru_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/lru_bitop.sv
// Combinational bitwise two-operand operator used as the fold step.
module lru_bitop
    import lru_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a ^ b;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = a ^ b;
        endcase
    end

endmodule

// File: rtl/logic_reduce_unit.sv
// Frame-wise bitwise fold (AND/OR/XOR/XNOR) with valid/ready on both sides.
// Optional registered even-parity output enabled by LOGIC_REDUCE_PARITY_EN.
module logic_reduce_unit
    import lru_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_parity
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_t                op_q, op_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [WIDTH-1:0]   fold_s;
    logic               in_fire_s;
    logic               out_fire_s;

    assign in_fire_s  = in_valid && in_ready_q;
    assign out_fire_s = out_valid_q && out_ready;

    lru_bitop #(.WIDTH(WIDTH)) u_bitop (
        .op (op_q),
        .a  (acc_q),
        .b  (in_data),
        .y  (fold_s)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    acc_d   = in_data;
                    op_d    = op_t'(op);
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_fire_s) begin
                    acc_d   = fold_s;
                    // Saturate rather than wrap; folding itself keeps going.
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and result registers are derived from the next state so
        // they are all flops yet line up with the state they describe.
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
        out_data_d  = (state_d == ST_HOLD) ? acc_d : '0;
        out_count_d = (state_d == ST_HOLD) ? cnt_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OP_AND;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

`ifdef LOGIC_REDUCE_PARITY_EN
    logic out_parity_q, out_parity_d;

    always_comb begin
        out_parity_d = (state_d == ST_HOLD) ? ^acc_d : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit (WIDTH=8, CNT_W=2): directed table,
// hand-written reset/backpressure sequences and random frames against a model.
module tb_logic_reduce_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk, rst;
    logic             in_valid, in_ready, in_last;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       op;
    logic             out_valid, out_ready, out_parity;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    int total = 0;
    int bad   = 0;

    logic_reduce_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_parity (out_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op0;
        logic [1:0]  opr;
        logic [3:0]  n;
        logic [63:0] d;
        logic [7:0]  ed;
        logic [1:0]  ec;
        logic [3:0]  bp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] v);
`ifdef LOGIC_REDUCE_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    // Column-wise model: each result bit depends only on how many of the n
    // words have that bit set.
    function automatic logic [7:0] model(input logic [1:0] o, input int n, input logic [63:0] d);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int c;
            c = 0;
            for (int i = 0; i < n; i++) c += int'(d[i*8+b]);
            case (o)
                2'd0:    r[b] = (c == n);
                2'd1:    r[b] = (c > 0);
                2'd2:    r[b] = (c % 2) == 1;
                default: r[b] = ((c + n - 1) % 2) == 1;
            endcase
        end
        return r;
    endfunction

    // Present a beat at a falling edge; return at the falling edge after acceptance.
    task automatic push(input logic [7:0] d, input logic l, input logic [1:0] o);
        logic done;
        logic rdy;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l; op = o;
        for (int t = 0; t < 20 && !done; t++) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            done = rdy;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL push_timeout: got ready=0 want ready=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_hold(input string nm, input logic [7:0] ed, input int ec);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_inrdy"}, in_ready, 0);
        chk({nm, "_data"},  out_data, ed);
        chk({nm, "_count"}, out_count, ec);
        chk({nm, "_par"},   out_parity, exp_par(ed));
    endtask

    task automatic run_frame(input string nm, input logic [1:0] op0, input logic [1:0] opr,
                             input int n, input logic [63:0] d, input logic [7:0] ed,
                             input int ec, input int gaps, input int bp);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    op       = 2'($urandom);
                    @(negedge clk);
                end
            end
            push(d[i*8 +: 8], (i == n - 1), (i == 0) ? op0 : opr);
        end
        in_last = 1'b0;
        in_data = 8'($urandom);
        chk_hold(nm, ed, ec);
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk_hold({nm, "_bp"}, ed, ec);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_rel_valid"}, out_valid, 0);
        chk({nm, "_rel_inrdy"}, in_ready, 1);
    endtask

    initial begin
        logic [1:0]  r_op0, r_opr;
        int          r_n;
        logic [63:0] r_d;
        int          r_ec;

        tbl[0] = '{op0:2'b00, opr:2'b00, n:4'd3, d:64'h0000_0000_00FF_3CF0, ed:8'h30, ec:2'd3, bp:4'd5};
        tbl[1] = '{op0:2'b10, opr:2'b10, n:4'd1, d:64'h0000_0000_0000_00A5, ed:8'hA5, ec:2'd1, bp:4'd0};
        tbl[2] = '{op0:2'b01, opr:2'b00, n:4'd2, d:64'h0000_0000_0000_0201, ed:8'h03, ec:2'd2, bp:4'd1};
        tbl[3] = '{op0:2'b10, opr:2'b10, n:4'd5, d:64'h0000_0001_0101_0101, ed:8'h01, ec:2'd3, bp:4'd2};
        tbl[4] = '{op0:2'b11, opr:2'b11, n:4'd2, d:64'h0000_0000_0000_0F0F, ed:8'hFF, ec:2'd2, bp:4'd0};
        tbl[5] = '{op0:2'b01, opr:2'b01, n:4'd4, d:64'h0000_0000_0804_0201, ed:8'h0F, ec:2'd3, bp:4'd3};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; op = 2'b00; out_ready = 1'b0;
        #12;
        chk("rst_inrdy", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_par",   out_parity, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("tbl%0d", v), tbl[v].op0, tbl[v].opr, int'(tbl[v].n),
                      tbl[v].d, tbl[v].ed, int'(tbl[v].ec), 0, int'(tbl[v].bp));
        end

        // Asynchronous reset in the middle of a frame discards it.
        push(8'h11, 1'b0, 2'b01);
        push(8'h22, 1'b0, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_inrdy", in_ready, 1);
        chk("midrst_count", out_count, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", 2'b11, 2'b11, 2, 64'h0F0F, 8'hFF, 2, 0, 0);

        // Asynchronous reset while a result is pending.
        push(8'h7E, 1'b1, 2'b10);
        chk_hold("pre_hrst", 8'h7E, 1);
        #2 rst = 1'b1;
        #1;
        chk("hrst_valid", out_valid, 0);
        chk("hrst_inrdy", in_ready, 1);
        chk("hrst_data",  out_data, 0);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int f = 0; f < 40; f++) begin
            r_op0 = 2'($urandom);
            r_opr = 2'($urandom);
            r_n   = $urandom_range(1, 8);
            r_d   = {$urandom, $urandom};
            r_ec  = (r_n > 3) ? 3 : r_n;
            run_frame($sformatf("rnd%0d", f), r_op0, r_opr, r_n, r_d,
                      model(r_op0, r_n, r_d), r_ec, 1, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
